// File: rtl/red_nibble_sub_serial.sv
// red_nibble_sub_serial
//   Multi-cycle WIDTH-bit subtractor built around a single 4-bit
//   carry-lookahead slice. It computes A - B as A + ~B + 1, one nibble per
//   clock, and passes the carry between nibbles in a register. Borrow and
//   signed-overflow flags are produced when the operation completes.
//
//   Parameters:
//     WIDTH   operand/result width; must be a multiple of 4 and >= 8
//
//   Ports:
//     clk    in   clock, rising edge
//     rst    in   asynchronous active-high reset
//     start  in   request, sampled only in IDLE
//     A      in   minuend, captured on an accepted start
//     B      in   subtrahend, captured on an accepted start
//     busy   out  high in RUN and DONE
//     done   out  one-cycle completion pulse
//     D      out  difference, held until the next accepted start
//     Bout   out  borrow out (unsigned A < B)
//     Ovfl   out  signed overflow of A - B
//
//   Optional build macro:
//     RED_SUB_SAT_EN  saturate D on signed overflow
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold the last result
//   RUN   | one nibble processed per cycle
//   DONE  | done pulse; result and flags valid
module red_nibble_sub_serial #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             Ovfl
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   nb_q, nb_d;      // holds ~B
    logic [WIDTH-1:0]   d_q, d_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               bout_q, bout_d;
    logic               ovfl_q, ovfl_d;

    // Carry-lookahead slice on the currently selected nibble
    logic [3:0] a_nib, b_nib, g, p, sum;
    logic [4:0] c;

    assign a_nib = a_q[{idx_q, 2'b00} +: 4];
    assign b_nib = nb_q[{idx_q, 2'b00} +: 4];
    assign g     = a_nib & b_nib;
    assign p     = a_nib ^ b_nib;

    assign c[0] = carry_q;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);
    assign sum  = p ^ c[3:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            nb_q    <= '0;
            d_q     <= '0;
            carry_q <= 1'b1;
            idx_q   <= '0;
            bout_q  <= 1'b0;
            ovfl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            nb_q    <= nb_d;
            d_q     <= d_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            bout_q  <= bout_d;
            ovfl_q  <= ovfl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        nb_d    = nb_q;
        d_d     = d_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        bout_d  = bout_q;
        ovfl_d  = ovfl_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = A;
                    nb_d    = ~B;
                    carry_d = 1'b1;
                    idx_d   = '0;
                    d_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                d_d[{idx_q, 2'b00} +: 4] = sum;
                carry_d = c[4];
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NIBBLES - 1)) begin
                    // Flags are registered on entry to DONE so they are
                    // valid in the same cycle as the done pulse.
                    state_d = S_DONE;
                    bout_d  = ~c[4];
                    // A and B differ in sign <=> a_q and ~B agree in sign
                    ovfl_d  = (a_q[WIDTH-1] == nb_q[WIDTH-1])
                            & (d_d[WIDTH-1] != a_q[WIDTH-1]);
`ifdef RED_SUB_SAT_EN
                    if (ovfl_d) begin
                        d_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                           : {1'b0, {(WIDTH-1){1'b1}}};
                    end
`else
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign D    = d_q;
    assign Bout = bout_q;
    assign Ovfl = ovfl_q;

endmodule
